laby7_serial_subtractor: RTL

LABY7_SERIAL_SUBTRACTOR -- requirements
Module: laby7_serial_subtractor

---
 rtl/laby7_serial_subtractor.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/laby7_serial_subtractor.sv
// ---------------------------------------------------------------------------
// laby7_serial_subtractor
//
// Bit-serial unsigned subtractor: computes a = y - b (mod 2^(W+1)) one bit
// per clock, LSB first, and reports the borrow out of the top bit on neg.
// Recovers an adder operand from its sum word and the other operand.
//
// Timeline for one operation (start sampled at edge 0):
//   edge 0        : IDLE -> RUN, operands latched
//   edges 1..W+1  : one result bit per edge; edge W+1 enters DONE and loads a/neg
//   edge W+2      : DONE -> IDLE; a new start is accepted on the edge after
//
// Ports
//   clk    in   sole clock, rising edge
//   rst    in   asynchronous active-high reset
//   start  in   begin a subtraction (sampled only in IDLE)
//   y      in   [W:0]   minuend
//   b      in   [W-1:0] subtrahend (zero-extended internally)
//   a      out  [W:0]   result, updated only on entry to DONE
//   neg    out  borrow out of bit W (y < b)
//   busy   out  high in RUN and DONE
//   done   out  one-cycle pulse while in DONE
// ---------------------------------------------------------------------------
module laby7_serial_subtractor #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W:0]   y,
  input  logic [W-1:0] b,
  output logic [W:0]   a,
  output logic         neg,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(W + 2);
  localparam logic [CW-1:0] LAST_BIT = CW'(W);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [W:0]    y_sr_q, y_sr_d;
  logic [W:0]    b_sr_q, b_sr_d;
  logic [W:0]    r_q, r_d;
  logic          br_q, br_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W:0]    a_q, a_d;
  logic          neg_q, neg_d;
  logic          done_q, done_d;

  // One full-subtractor slice on the current LSBs.
  logic yb, bb, diff_bit, br_next;
  assign yb       = y_sr_q[0];
  assign bb       = b_sr_q[0];
  assign diff_bit = yb ^ bb ^ br_q;
  assign br_next  = (~yb & bb) | (~(yb ^ bb) & br_q);

  // NOTE: combinational next-state logic uses blocking assignments and gives
  // every signal a default first, so no path leaves a latch behind.
  always_comb begin
    state_d = state_q;
    y_sr_d  = y_sr_q;
    b_sr_d  = b_sr_q;
    r_d     = r_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    neg_d   = neg_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          y_sr_d  = y;
          b_sr_d  = {1'b0, b};
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        r_d    = {diff_bit, r_q[W:1]};
        y_sr_d = y_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        br_d   = br_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // The final bit goes straight into a, so partial results in r_q
          // never reach the output.
          a_d     = {diff_bit, r_q[W:1]};
          neg_d   = br_next;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the datapath
  // registers are small flops (not a memory), so all of them are reset so an
  // aborted operation leaves nothing stale behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      y_sr_q  <= '0;
      b_sr_q  <= '0;
      r_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      a_q     <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_sr_q  <= y_sr_d;
      b_sr_q  <= b_sr_d;
      r_q     <= r_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
    end
  end

  assign a    = a_q;
  assign neg  = neg_q;
  assign done = done_q;
  assign busy = (state_q != S_IDLE);

endmodule
